// File: rtl/image_stream_buffer_pkg.sv
// Shared types and helpers for the image stream buffer.
// Optional build macro: IMAGE_STREAM_TEST_PATTERN_EN (checkerboard preload of known slot 0).
package image_stream_pkg;

    typedef enum logic [2:0] {
        CMD_CLR            = 3'b000,
        CMD_KNOWN          = 3'b001,
        CMD_KNOWN_INC_DIFF = 3'b010,
        CMD_INC_DIFF       = 3'b011,
        CMD_UNKNOWN        = 3'b100,
        CMD_WRITE          = 3'b101,
        CMD_RESET_DISTANCE = 3'b110,
        CMD_NOP            = 3'b111
    } cmd_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_e;

    localparam int IMG_SIDE    = 28;
    localparam int NUM_PIX_DEF = 784;

    // Checkerboard: 1 means an all-ones pixel. Even rows start with ones,
    // odd rows start with zero, alternating along the row.
    function automatic logic pattern_pix(input int unsigned addr);
        int unsigned row;
        int unsigned col;
        row = addr / IMG_SIDE;
        col = addr % IMG_SIDE;
        return (((row + col) & 32'd1) == 32'd0);
    endfunction

endpackage

// File: rtl/image_stream_buffer_dist_serializer.sv
// Distance snapshot and byte-serial readout to the host bus.
// A result arriving mid-readout is parked in a pending register and only
// becomes visible once the byte index returns to 0, so the host never sees
// bytes from two different results in one readout.
module dist_serializer #(
    parameter int PIX_W  = 8,
    parameter int DIST_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_cmd,
    input  logic              rst_dist,
    input  logic              clr_idx,
    input  logic [DIST_W-1:0] distance,
    input  logic              dist_valid,
    input  logic              toggle_write,
    output logic [PIX_W-1:0]  bus_out,
    output logic              bus_oe,
    output logic              dist_done
);
    localparam int NB    = DIST_W / PIX_W;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DIST_W-1:0] snap_q, snap_d;
    logic [DIST_W-1:0] pend_q, pend_d;
    logic              pend_vld_q, pend_vld_d;
    logic              dist_done_q, dist_done_d;
    logic              wrap, back_to_zero, pend_take;

    // Next index, snapshot and pending-register update
    always_comb begin
        wrap         = wr_cmd && (idx_q == IDX_W'(NB - 1));
        idx_d        = idx_q;
        snap_d       = snap_q;
        pend_d       = pend_q;
        pend_vld_d   = pend_vld_q;
        dist_done_d  = wrap;
        if (rst_dist || clr_idx || wrap)
            idx_d = '0;
        else if (wr_cmd)
            idx_d = idx_q + IDX_W'(1);
        back_to_zero = (idx_q != '0) && (idx_d == '0);
        pend_take    = dist_valid && (idx_q != '0);
        if (rst_dist) begin
            snap_d     = '0;
            pend_d     = '0;
            pend_vld_d = 1'b0;
        end else if (dist_valid && (idx_q == '0)) begin
            snap_d = distance;
        end else if (back_to_zero) begin
            // A result landing on the wrap cycle goes straight through pending
            if (pend_take)
                snap_d = distance;
            else if (pend_vld_q)
                snap_d = pend_q;
            pend_vld_d = 1'b0;
        end else if (pend_take) begin
            pend_d     = distance;
            pend_vld_d = 1'b1;
        end
    end

    // Serializer state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q       <= '0;
            snap_q      <= '0;
            pend_q      <= '0;
            pend_vld_q  <= 1'b0;
            dist_done_q <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            snap_q      <= snap_d;
            pend_q      <= pend_d;
            pend_vld_q  <= pend_vld_d;
            dist_done_q <= dist_done_d;
        end
    end

    // Byte select from the snapshot, least-significant byte first
    always_comb begin
        bus_out = '0;
        for (int i = 0; i < NB; i++)
            if (idx_q == IDX_W'(i))
                bus_out = snap_q[i*PIX_W +: PIX_W];
    end

    assign bus_oe    = toggle_write;
    assign dist_done = dist_done_q;

endmodule

// File: rtl/image_stream_buffer.sv
// Image load/readback buffer between the host byte bus and the distance engine.
// Known slots and the unknown image are filled byte-serially through a shared
// pixel pointer; a registered read port serves pixels to the engine.
// Optional build macro: IMAGE_STREAM_TEST_PATTERN_EN adds an INIT state that
// writes a checkerboard into known slot 0 after reset; without it the memory
// has no initialisation path and stays RAM-inferable.
module image_stream_buffer
    import image_stream_pkg::*;
#(
    parameter int PIX_W     = 8,
    parameter int NUM_PIX   = NUM_PIX_DEF,
    parameter int NUM_SLOTS = 4,
    parameter int DIST_W    = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [2:0]                   cmd,
    input  logic                         cmd_valid,
    input  logic [$clog2(NUM_SLOTS)-1:0] slot_sel,
    input  logic [PIX_W-1:0]             bus_in,
    output logic [PIX_W-1:0]             bus_out,
    output logic                         bus_oe,
    input  logic                         toggle_write,
    input  logic [DIST_W-1:0]            distance,
    input  logic                         dist_valid,
    input  logic                         rd_unknown,
    input  logic [$clog2(NUM_SLOTS)-1:0] rd_slot,
    input  logic [$clog2(NUM_PIX)-1:0]   rd_addr,
    output logic [PIX_W-1:0]             rd_data,
    output logic                         diff_inc,
    output logic                         image_done,
    output logic                         dist_done,
    output logic [NUM_SLOTS:0]           slot_loaded,
    output logic                         busy,
    output logic                         cmd_err
);
    localparam int PTR_W  = $clog2(NUM_PIX);
    localparam int SLOT_W = $clog2(NUM_SLOTS);

    logic [PIX_W-1:0] known_mem [NUM_SLOTS][NUM_PIX];
    logic [PIX_W-1:0] unk_mem   [NUM_PIX];

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [NUM_SLOTS:0] loaded_q, loaded_d;
    logic               diff_inc_q, diff_inc_d;
    logic               image_done_q, image_done_d;
    logic               cmd_err_q, cmd_err_d;
    logic [PIX_W-1:0]   rd_data_q, rd_data_d;

    logic               kwr_en, uwr_en, cmd_wr;
    logic [SLOT_W-1:0]  wr_slot;
    logic [PIX_W-1:0]   wr_data;
    logic               ptr_last;
    logic               ser_wr, ser_rst, ser_clr;

    // FSM next state, command decode, pointer and flag updates
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        loaded_d     = loaded_q;
        diff_inc_d   = 1'b0;
        image_done_d = 1'b0;
        cmd_err_d    = 1'b0;
        kwr_en       = 1'b0;
        uwr_en       = 1'b0;
        cmd_wr       = 1'b0;
        wr_slot      = slot_sel;
        wr_data      = bus_in;
        ser_wr       = 1'b0;
        ser_rst      = 1'b0;
        ser_clr      = 1'b0;
        ptr_last     = (ptr_q == PTR_W'(NUM_PIX - 1));
        case (state_q)
            ST_INIT: begin
`ifdef IMAGE_STREAM_TEST_PATTERN_EN
                // Host commands are dropped while the pattern is written
                cmd_err_d = cmd_valid;
                kwr_en    = 1'b1;
                wr_slot   = '0;
                wr_data   = {PIX_W{pattern_pix(32'(ptr_q))}};
                if (ptr_last) begin
                    ptr_d       = '0;
                    loaded_d[0] = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    ptr_d = ptr_q + PTR_W'(1);
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: begin
                if (cmd_valid) begin
                    case (cmd_e'(cmd))
                        CMD_KNOWN: begin
                            kwr_en = 1'b1;
                            cmd_wr = 1'b1;
                        end
                        CMD_KNOWN_INC_DIFF: begin
                            kwr_en     = 1'b1;
                            cmd_wr     = 1'b1;
                            diff_inc_d = 1'b1;
                        end
                        CMD_INC_DIFF:       diff_inc_d = 1'b1;
                        CMD_UNKNOWN: begin
                            uwr_en = 1'b1;
                            cmd_wr = 1'b1;
                        end
                        CMD_WRITE:          ser_wr  = 1'b1;
                        CMD_RESET_DISTANCE: ser_rst = 1'b1;
                        CMD_CLR: begin
                            ptr_d    = '0;
                            loaded_d = '0;
                            ser_clr  = 1'b1;
                        end
                        default: ;
                    endcase
                end
                // Pixel writes advance the shared pointer and flag full images
                if (cmd_wr) begin
                    if (ptr_last) begin
                        ptr_d        = '0;
                        image_done_d = 1'b1;
                        if (uwr_en)
                            loaded_d[NUM_SLOTS] = 1'b1;
                        else
                            loaded_d[slot_sel] = 1'b1;
                    end else begin
                        ptr_d = ptr_q + PTR_W'(1);
                    end
                end
            end
        endcase
    end

    // Control registers; reset lands in INIT only when the pattern is built in
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
`ifdef IMAGE_STREAM_TEST_PATTERN_EN
            state_q      <= ST_INIT;
`else
            state_q      <= ST_IDLE;
`endif
            ptr_q        <= '0;
            loaded_q     <= '0;
            diff_inc_q   <= 1'b0;
            image_done_q <= 1'b0;
            cmd_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            loaded_q     <= loaded_d;
            diff_inc_q   <= diff_inc_d;
            image_done_q <= image_done_d;
            cmd_err_q    <= cmd_err_d;
        end
    end

    // Image memory writes; no reset so contents survive reset
    always_ff @(posedge clk) begin
        if (kwr_en)
            known_mem[wr_slot][ptr_q] <= wr_data;
        if (uwr_en)
            unk_mem[ptr_q] <= wr_data;
    end

    // Read port mux; registered below so a same-cycle write returns old data
    always_comb begin
        rd_data_d = rd_unknown ? unk_mem[rd_addr] : known_mem[rd_slot][rd_addr];
    end

    // Registered read data
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rd_data_q <= '0;
        else
            rd_data_q <= rd_data_d;
    end

    dist_serializer #(
        .PIX_W  (PIX_W),
        .DIST_W (DIST_W)
    ) u_ser (
        .clk          (clk),
        .reset        (reset),
        .wr_cmd       (ser_wr),
        .rst_dist     (ser_rst),
        .clr_idx      (ser_clr),
        .distance     (distance),
        .dist_valid   (dist_valid),
        .toggle_write (toggle_write),
        .bus_out      (bus_out),
        .bus_oe       (bus_oe),
        .dist_done    (dist_done)
    );

    assign rd_data     = rd_data_q;
    assign diff_inc    = diff_inc_q;
    assign image_done  = image_done_q;
    assign cmd_err     = cmd_err_q;
    assign slot_loaded = loaded_q;
`ifdef IMAGE_STREAM_TEST_PATTERN_EN
    assign busy = (state_q == ST_INIT);
`else
    assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_image_stream_buffer.sv
// Directed bench for image_stream_buffer with hand-computed expectations.
module tb_image_stream_buffer;
    import image_stream_pkg::*;

    localparam int PIX_W = 8, NUM_PIX = 784, NUM_SLOTS = 4, DIST_W = 32;
`ifdef IMAGE_STREAM_TEST_PATTERN_EN
    localparam logic [4:0] LOADED0  = 5'b00001;
    localparam logic       BUSY_RST = 1'b1;
`else
    localparam logic [4:0] LOADED0  = 5'b00000;
    localparam logic       BUSY_RST = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [2:0]        cmd;
    logic              cmd_valid;
    logic [1:0]        slot_sel;
    logic [7:0]        bus_in;
    logic [7:0]        bus_out;
    logic              bus_oe;
    logic              toggle_write;
    logic [31:0]       distance;
    logic              dist_valid;
    logic              rd_unknown;
    logic [1:0]        rd_slot;
    logic [9:0]        rd_addr;
    logic [7:0]        rd_data;
    logic              diff_inc, image_done, dist_done, busy, cmd_err;
    logic [4:0]        slot_loaded;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    image_stream_buffer #(
        .PIX_W(PIX_W), .NUM_PIX(NUM_PIX), .NUM_SLOTS(NUM_SLOTS), .DIST_W(DIST_W)
    ) dut (
        .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
        .slot_sel(slot_sel), .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
        .toggle_write(toggle_write), .distance(distance), .dist_valid(dist_valid),
        .rd_unknown(rd_unknown), .rd_slot(rd_slot), .rd_addr(rd_addr),
        .rd_data(rd_data), .diff_inc(diff_inc), .image_done(image_done),
        .dist_done(dist_done), .slot_loaded(slot_loaded), .busy(busy),
        .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One command, applied over one clock edge; outputs are sampled 1 after it
    task automatic step(input logic [2:0] c, input logic [7:0] b, input logic [1:0] s);
        cmd = c; bus_in = b; slot_sel = s; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd = CMD_NOP;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    task automatic rd(input logic unk, input logic [1:0] s, input logic [9:0] a,
                      output logic [7:0] d);
        rd_unknown = unk; rd_slot = s; rd_addr = a;
        @(posedge clk); #1;
        d = rd_data;
    endtask

`ifdef IMAGE_STREAM_TEST_PATTERN_EN
    task automatic wait_init(output int n);
        n = 0;
        while (busy && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
    endtask
`endif

    initial begin
        logic [7:0]  d;
        logic [31:0] dexp;
        int          cnt;
        reset = 1'b1; cmd = CMD_NOP; cmd_valid = 1'b0; slot_sel = '0; bus_in = '0;
        toggle_write = 1'b0; distance = '0; dist_valid = 1'b0;
        rd_unknown = 1'b0; rd_slot = '0; rd_addr = '0;
        #12;
        check("rst_bus_out", 32'(bus_out), 32'h0);
        check("rst_rd_data", 32'(rd_data), 32'h0);
        check("rst_diff_inc", 32'(diff_inc), 32'h0);
        check("rst_image_done", 32'(image_done), 32'h0);
        check("rst_dist_done", 32'(dist_done), 32'h0);
        check("rst_slot_loaded", 32'(slot_loaded), 32'h0);
        check("rst_cmd_err", 32'(cmd_err), 32'h0);
        check("rst_busy", 32'(busy), 32'(BUSY_RST));
        @(negedge clk);
        reset = 1'b0;
`ifdef IMAGE_STREAM_TEST_PATTERN_EN
        wait_init(cnt);
        check("init_busy_cycles", 32'(cnt), 32'd784);
        rd(1'b0, 2'd0, 10'd0, d);  check("pat_addr0", 32'(d), 32'hFF);
        rd(1'b0, 2'd0, 10'd1, d);  check("pat_addr1", 32'(d), 32'h00);
        rd(1'b0, 2'd0, 10'd28, d); check("pat_addr28", 32'(d), 32'h00);
        rd(1'b0, 2'd0, 10'd29, d); check("pat_addr29", 32'(d), 32'hFF);
        check("init_loaded", 32'(slot_loaded), 32'(LOADED0));
`else
        idle();
`endif

        // Full known image into slot 2, pixel value = low address byte
        cnt = 0;
        for (int i = 0; i < NUM_PIX; i++) begin
            step(CMD_KNOWN, 8'(i), 2'd2);
            if (image_done) cnt++;
        end
        check("image_done_last", 32'(image_done), 32'h1);
        check("image_done_count", 32'(cnt), 32'd1);
        idle();
        check("image_done_clear", 32'(image_done), 32'h0);
        check("slot2_loaded", 32'(slot_loaded), 32'(LOADED0 | 5'b00100));
        rd(1'b0, 2'd2, 10'd300, d); check("slot2_addr300", 32'(d), 32'h2C);
        rd(1'b0, 2'd2, 10'd783, d); check("slot2_addr783", 32'(d), 32'h0F);
        rd(1'b0, 2'd2, 10'd0, d);   check("slot2_addr0", 32'(d), 32'h00);

        // Snapshot at idx 0, then byte-serial readout
        distance = 32'hA1B2C3D4; dist_valid = 1'b1;
        idle();
        dist_valid = 1'b0;
        toggle_write = 1'b1; #1;
        check("bus_oe_on", 32'(bus_oe), 32'h1);
        dexp = 32'hA1B2C3D4;
        for (int k = 0; k < 4; k++) begin
            check("readout_byte", 32'(bus_out), 32'(dexp[k*8 +: 8]));
            step(CMD_WRITE, 8'h00, 2'd0);
        end
        check("dist_done_pulse", 32'(dist_done), 32'h1);
        check("readout_wrapped", 32'(bus_out), 32'hD4);
        idle();
        check("dist_done_clear", 32'(dist_done), 32'h0);
        toggle_write = 1'b0; #1;
        check("bus_oe_off", 32'(bus_oe), 32'h0);

        // New result mid-readout is held until the wrap
        step(CMD_WRITE, 8'h00, 2'd0);
        step(CMD_WRITE, 8'h00, 2'd0);
        distance = 32'h11223344; dist_valid = 1'b1;
        idle();
        dist_valid = 1'b0;
        check("pend_old_b2", 32'(bus_out), 32'hB2);
        step(CMD_WRITE, 8'h00, 2'd0);
        check("pend_old_b3", 32'(bus_out), 32'hA1);
        step(CMD_WRITE, 8'h00, 2'd0);
        check("pend_new_b0", 32'(bus_out), 32'h44);
        check("pend_dist_done", 32'(dist_done), 32'h1);

        // Result arriving together with the final WRITE
        step(CMD_WRITE, 8'h00, 2'd0);
        step(CMD_WRITE, 8'h00, 2'd0);
        step(CMD_WRITE, 8'h00, 2'd0);
        check("pre_wrap_b3", 32'(bus_out), 32'h11);
        distance = 32'h55667788; dist_valid = 1'b1;
        step(CMD_WRITE, 8'h00, 2'd0);
        dist_valid = 1'b0;
        check("simul_wrap_b0", 32'(bus_out), 32'h88);

        // RESET_DISTANCE clears snapshot and index
        step(CMD_WRITE, 8'h00, 2'd0);
        check("pre_rstd_b1", 32'(bus_out), 32'h77);
        step(CMD_RESET_DISTANCE, 8'h00, 2'd0);
        check("rstd_bus_out", 32'(bus_out), 32'h00);
        distance = 32'hCAFE0042; dist_valid = 1'b1;
        idle();
        dist_valid = 1'b0;
        check("rstd_reload", 32'(bus_out), 32'h42);

        // CLR drops loaded flags and rewinds the pointer
        step(CMD_CLR, 8'h00, 2'd0);
        check("clr_loaded", 32'(slot_loaded), 32'h0);

        // diff_inc pulses; first write collides with a read of the same address
        cnt = 0;
        rd_unknown = 1'b0; rd_slot = 2'd2; rd_addr = 10'd0;
        step(CMD_KNOWN_INC_DIFF, 8'hAA, 2'd2);
        check("collision_old", 32'(rd_data), 32'h00);
        if (diff_inc) cnt++;
        step(CMD_KNOWN_INC_DIFF, 8'hBB, 2'd2);
        if (diff_inc) cnt++;
        step(CMD_KNOWN_INC_DIFF, 8'hCC, 2'd2);
        if (diff_inc) cnt++;
        step(CMD_INC_DIFF, 8'hEE, 2'd2);
        if (diff_inc) cnt++;
        check("diff_inc_count", 32'(cnt), 32'd4);
        idle();
        check("diff_inc_clear", 32'(diff_inc), 32'h0);
        step(CMD_UNKNOWN, 8'h5A, 2'd0);
        rd(1'b1, 2'd0, 10'd3, d); check("ptr3_unknown", 32'(d), 32'h5A);
        rd(1'b0, 2'd2, 10'd0, d); check("kid_addr0", 32'(d), 32'hAA);
        rd(1'b0, 2'd2, 10'd2, d); check("kid_addr2", 32'(d), 32'hCC);
        rd(1'b0, 2'd2, 10'd3, d); check("inc_diff_nowrite", 32'(d), 32'h03);

        // Reset in the middle of an unknown load and a readout
        step(CMD_CLR, 8'h00, 2'd0);
        for (int i = 0; i < 100; i++)
            step(CMD_UNKNOWN, 8'(i + 1), 2'd0);
        step(CMD_WRITE, 8'h00, 2'd0);
        step(CMD_WRITE, 8'h00, 2'd0);
        check("pre_reset_b2", 32'(bus_out), 32'hFE);
        #2 reset = 1'b1;
        #1;
        check("midrst_bus_out", 32'(bus_out), 32'h0);
        check("midrst_rd_data", 32'(rd_data), 32'h0);
        check("midrst_loaded", 32'(slot_loaded), 32'h0);
        check("midrst_busy", 32'(busy), 32'(BUSY_RST));
        @(negedge clk);
        reset = 1'b0;
`ifdef IMAGE_STREAM_TEST_PATTERN_EN
        #1;
        step(CMD_KNOWN, 8'h99, 2'd3);
        check("init_cmd_err", 32'(cmd_err), 32'h1);
        wait_init(cnt);
        check("reinit_done", 32'(busy), 32'h0);
        check("reinit_loaded", 32'(slot_loaded), 32'h1);
`endif
        step(CMD_UNKNOWN, 8'hEE, 2'd0);
        check("postrst_cmd_err", 32'(cmd_err), 32'h0);
        rd(1'b1, 2'd0, 10'd0, d);  check("postrst_ptr0", 32'(d), 32'hEE);
        rd(1'b1, 2'd0, 10'd1, d);  check("retained_u1", 32'(d), 32'h02);
        rd(1'b1, 2'd0, 10'd50, d); check("retained_u50", 32'(d), 32'h33);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
